// File: rtl/bcd_disp_scan.sv
// Display back-end: converts an 8-bit signed-magnitude result to BCD with a
// sequential double-dabble engine and scans it onto a 4-digit common-anode display.
module bcd_disp_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Load,
    input  logic [7:0] Mag,
    input  logic       Sign,
    output logic       Busy,
    output logic [6:0] Seg,
    output logic [3:0] An
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [19:0] shift_reg, shift_next;
    logic [19:0] adj;
    logic [2:0]  step_reg, step_next;
    logic        neg_reg, neg_next;
    logic        disp_load;

    logic [3:0]  hund_reg, tens_reg, ones_reg;
    logic        disp_neg_reg;

    logic [DW-1:0] div_reg;
    logic          div_tc;
    logic [1:0]    idx_reg, idx_next;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    // Add-3 correction on each BCD nibble of {bcd[11:0], bin[7:0]}
    assign adj[7:0] = shift_reg[7:0];
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
            assign adj[8+4*gi +: 4] = (shift_reg[8+4*gi +: 4] >= 4'd5)
                                    ? shift_reg[8+4*gi +: 4] + 4'd3
                                    : shift_reg[8+4*gi +: 4];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        step_next  = step_reg;
        neg_next   = neg_reg;
        disp_load  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Load) begin
                    shift_next = {12'd0, Mag};
                    step_next  = 3'd0;
                    neg_next   = Sign && (Mag != 8'd0);
                    state_next = CONV;
                end
            end
            CONV: begin
                shift_next = adj << 1;
                step_next  = step_reg + 3'd1;
                if (step_reg == 3'd7) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                disp_load  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            step_reg     <= '0;
            neg_reg      <= 1'b0;
            hund_reg     <= '0;
            tens_reg     <= '0;
            ones_reg     <= '0;
            disp_neg_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            step_reg  <= step_next;
            neg_reg   <= neg_next;
            // All digits and the sign change together so no mixed value is ever scanned
            if (disp_load) begin
                hund_reg     <= shift_reg[19:16];
                tens_reg     <= shift_reg[15:12];
                ones_reg     <= shift_reg[11:8];
                disp_neg_reg <= neg_reg;
            end
        end
    end

    assign Busy = (state_reg != IDLE);

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = GLYPH_BLANK;
        endcase
    endfunction

    assign div_tc   = (div_reg == DW'(SCAN_DIV - 1));
    assign idx_next = div_tc ? idx_reg + 2'd1 : idx_reg;

    // Segments are chosen from the index the scan is moving to, so An and Seg stay aligned
    always_comb begin
        seg_next = GLYPH_BLANK;
        case (idx_next)
            2'd3: seg_next = disp_neg_reg ? GLYPH_MINUS : GLYPH_BLANK;
            2'd2: seg_next = (hund_reg == 4'd0) ? GLYPH_BLANK : glyph(hund_reg);
            2'd1: seg_next = (hund_reg == 4'd0 && tens_reg == 4'd0) ? GLYPH_BLANK : glyph(tens_reg);
            default: seg_next = glyph(ones_reg);
        endcase
        an_next = ~(4'b0001 << idx_next);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_reg <= '0;
            idx_reg <= '0;
            Seg     <= 7'b1000000;
            An      <= 4'b1110;
        end else begin
            div_reg <= div_tc ? '0 : div_reg + DW'(1);
            idx_reg <= idx_next;
            Seg     <= seg_next;
            An      <= an_next;
        end
    end

endmodule
